// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared types and constants for the data-memory access unit
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } mau_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] DM_WEB_IDLE = 4'hF;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response bus between EX/MEM stage and the access unit
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        memread;
  logic        memwrite;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, memread, memwrite, func3, addr, wdata,
    input  req_ready, stall, resp_valid, rdata, err
  );

  modport slave (
    input  req_valid, memread, memwrite, func3, addr, wdata,
    output req_ready, stall, resp_valid, rdata, err
  );
endinterface

// File: rtl/mau_load_align.sv
// rtl/mau_load_align.sv - load lane select with sign/zero extension
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {off, 3'b000};
    case (func3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I data-memory access unit; MAU_MISALIGN_CHECK_EN enables misalignment errors
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    bus,
  output logic                dm_cs,
  output logic                dm_oe,
  output logic [3:0]          dm_web,
  output logic [AW-1:0]       dm_addr,
  output logic [31:0]         dm_di,
  input  logic [31:0]         dm_do
);

  mau_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [2:0]  cnt;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  off_in;
  logic        misalign;
  logic        bad_req;
  logic [31:0] di_rep;
  logic [3:0]  web_st;
  logic [31:0] load_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[31:AW+2];

  // The offset is forced to the access's natural alignment, so lanes never straddle.
  always_comb begin
    case (bus.func3)
      F3_H, F3_HU: off_in = {bus.addr[1], 1'b0};
      F3_W:        off_in = 2'b00;
      default:     off_in = bus.addr[1:0];
    endcase
`ifdef MAU_MISALIGN_CHECK_EN
    misalign = (off_in != bus.addr[1:0]);
`else
    misalign = 1'b0;
`endif
    bad_req = (bus.memread && bus.memwrite)
            || (bus.memread  && !f3_legal(1'b0, bus.func3))
            || (bus.memwrite && !f3_legal(1'b1, bus.func3))
            || ((bus.memread || bus.memwrite) && misalign);
    case (bus.func3)
      F3_B:    di_rep = {4{bus.wdata[7:0]}};
      F3_H:    di_rep = {2{bus.wdata[15:0]}};
      default: di_rep = bus.wdata;
    endcase
    case (bus.func3)
      F3_B:    web_st = ~(4'b0001 << off_in);
      F3_H:    web_st = off_in[1] ? 4'b0011 : 4'b1100;
      default: web_st = 4'b0000;
    endcase
  end

  mau_load_align u_align (
    .word  (dm_do),
    .off   (off_q),
    .func3 (f3_q),
    .data  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      dm_cs        <= 1'b0;
      dm_oe        <= 1'b0;
      dm_web       <= DM_WEB_IDLE;
      dm_addr      <= '0;
      dm_di        <= 32'd0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      cnt          <= 3'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            f3_q        <= bus.func3;
            off_q       <= off_in;
            dm_addr     <= bus.addr[AW+1:2];
            if (bad_req) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b1;
              rdata_q      <= 32'd0;
            end else if (bus.memwrite) begin
              state  <= WRITE;
              dm_cs  <= 1'b1;
              dm_web <= web_st;
              dm_di  <= di_rep;
            end else if (bus.memread) begin
              state <= RWAIT;
              dm_cs <= 1'b1;
              dm_oe <= 1'b1;
              cnt   <= 3'(MEM_LAT);
            end else begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b0;
              rdata_q      <= 32'd0;
            end
          end
        end
        WRITE: begin
          state        <= RESP;
          dm_cs        <= 1'b0;
          dm_web       <= DM_WEB_IDLE;
          resp_valid_q <= 1'b1;
          err_q        <= 1'b0;
          rdata_q      <= 32'd0;
        end
        RWAIT: begin
          if (cnt == 3'd1) begin
            state        <= RESP;
            dm_cs        <= 1'b0;
            dm_oe        <= 1'b0;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b0;
            rdata_q      <= load_data;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;
  assign bus.stall      = (state == IDLE && bus.req_valid) || state == WRITE || state == RWAIT;

endmodule
